// File: rtl/image_hpf_filter.sv
// Streaming 3x3 high-pass filter: four rotating line buffers feed a
// column-serial convolution pass that emits one filtered row per stored row.
module image_hpf_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_image_pixel,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_conv_pixel
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = DATA_WIDTH + 3;
  localparam int SW = DATA_WIDTH + 5;

  typedef enum logic [1:0] {IDLE, RUN, RUN_PENDING} state_t;

  state_t                  state_q;
  logic [AW-1:0]           wrCol_q;
  logic [AW-1:0]           rdCol_q;
  logic [AW-1:0]           rdColNext;
  logic [1:0]              wrBuf_q;
  logic [1:0]              rowCnt_q;
  logic [1:0]              passBuf_q;
  logic [1:0]              pendBuf_q;
  logic [DATA_WIDTH-1:0]   lb_q [4][DEPTH];

  logic                    accept;
  logic                    rowDone;
  logic                    trigger;
  logic                    active;
  logic                    rdLast;

  logic [DATA_WIDTH-1:0]   rdCur  [3];
  logic [DATA_WIDTH-1:0]   rdNext [3];
  logic [DATA_WIDTH-1:0]   winL_q [3];
  logic [DATA_WIDTH-1:0]   winM_q [3];
  logic [DATA_WIDTH-1:0]   winR_q [3];
  logic                    winValid_q;
  logic                    sumValid_q;
  logic [NW-1:0]           nbSum_d;
  logic signed [SW-1:0]    sum_d;
  logic signed [SW-1:0]    sum_q;
  logic [DATA_WIDTH-1:0]   clamp_d;

  assign o_ready   = (state_q != RUN_PENDING);
  assign accept    = i_valid && o_ready;
  assign rowDone   = accept && (wrCol_q == AW'(DEPTH - 1));
  assign trigger   = rowDone && (rowCnt_q >= 2'd2);
  assign active    = (state_q != IDLE);
  assign rdLast    = (rdCol_q == AW'(DEPTH - 1));
  assign rdColNext = rdCol_q + 1'b1;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[wrBuf_q][wrCol_q] <= i_image_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrCol_q  <= '0;
      wrBuf_q  <= '0;
      rowCnt_q <= '0;
    end else if (accept) begin
      wrCol_q <= wrCol_q + 1'b1;
      if (rowDone) begin
        wrBuf_q <= wrBuf_q + 2'd1;
        if (rowCnt_q != 2'd3) begin
          rowCnt_q <= rowCnt_q + 2'd1;
        end
      end
    end
  end

  // The buffer index captured at trigger time is the newest row of the pass window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rdCol_q   <= '0;
      passBuf_q <= '0;
      pendBuf_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rdCol_q <= '0;
          if (trigger) begin
            state_q   <= RUN;
            passBuf_q <= wrBuf_q;
          end
        end
        RUN: begin
          rdCol_q <= rdColNext;
          if (rdLast) begin
            if (trigger) begin
              passBuf_q <= wrBuf_q;
            end else begin
              state_q <= IDLE;
            end
          end else if (trigger) begin
            state_q   <= RUN_PENDING;
            pendBuf_q <= wrBuf_q;
          end
        end
        RUN_PENDING: begin
          rdCol_q <= rdColNext;
          if (rdLast) begin
            state_q   <= RUN;
            passBuf_q <= pendBuf_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rdCur[r]  = lb_q[passBuf_q - 2'(2 - r)][rdCol_q];
      rdNext[r] = rdLast ? '0 : lb_q[passBuf_q - 2'(2 - r)][rdColNext];
    end
  end

  always_comb begin
    nbSum_d = NW'(winM_q[0]) + NW'(winM_q[2]);
    for (int r = 0; r < 3; r++) begin
      nbSum_d = nbSum_d + NW'(winL_q[r]) + NW'(winR_q[r]);
    end
    sum_d = SW'({winM_q[1], 3'b000}) - SW'(nbSum_d);
  end

  always_comb begin
    if (sum_q[SW-1]) begin
      clamp_d = '0;
    end else if (|sum_q[SW-2:DATA_WIDTH]) begin
      clamp_d = '1;
    end else begin
      clamp_d = sum_q[DATA_WIDTH-1:0];
    end
  end

  // Left column reuses the previous centre column, forced to zero at column 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      winValid_q   <= 1'b0;
      sumValid_q   <= 1'b0;
      o_valid      <= 1'b0;
      o_conv_pixel <= '0;
    end else begin
      winValid_q <= active;
      sumValid_q <= winValid_q;
      o_valid    <= sumValid_q;
      if (active) begin
        for (int r = 0; r < 3; r++) begin
          winL_q[r] <= (rdCol_q == '0) ? '0 : winM_q[r];
          winM_q[r] <= rdCur[r];
          winR_q[r] <= rdNext[r];
        end
      end
      if (winValid_q) begin
        sum_q <= sum_d;
      end
      if (sumValid_q) begin
        o_conv_pixel <= clamp_d;
      end
    end
  end

endmodule

// File: tb/tb_image_hpf_filter.sv
// Scoreboard bench for image_hpf_filter: a row-level reference model predicts
// every filtered pixel and the clock edge on which it must appear.
module tb_image_hpf_filter;

  localparam int DW      = 8;
  localparam int D       = 8;
  localparam int MAXROWS = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_image_pixel = '0;
  logic          o_ready;
  logic          o_valid;
  logic [DW-1:0] o_conv_pixel;

  image_hpf_filter #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_image_pixel(i_image_pixel),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_conv_pixel (o_conv_pixel)
  );

  always #5 clk = ~clk;

  int edgeCnt = 0;
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  typedef struct {
    int pix;
    int expEdge;
  } exp_t;

  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   inReset    = 1'b1;
  int   lastOut    = 0;
  int   outIdx     = 0;
  int   outImg [MAXROWS][D];
  int   img    [MAXROWS][D];
  int   hist   [3][D];
  int   curRow [D];
  int   col       = 0;
  int   rowsDone  = 0;
  int   nextStart = 0;

  function automatic void checkOutput(string name, int actual, int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCnt);
    end
  endfunction

  // 9*centre minus the whole 3x3 sum equals 8*centre minus the neighbours.
  function automatic int refPixel(int c);
    int s;
    int cc;
    s = 9 * hist[1][c];
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        cc = c + dc;
        if (cc >= 0 && cc < D) s -= hist[dr][cc];
      end
    end
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic modelAccept(input int pix, input int accEdge);
    int p;
    curRow[col] = pix;
    col++;
    if (col == D) begin
      col = 0;
      rowsDone++;
      for (int c = 0; c < D; c++) begin
        hist[0][c] = hist[1][c];
        hist[1][c] = hist[2][c];
        hist[2][c] = curRow[c];
      end
      if (rowsDone >= 3) begin
        p = (accEdge > nextStart) ? accEdge : nextStart;
        nextStart = p + D;
        for (int c = 0; c < D; c++) sbQ.push_back('{refPixel(c), p + 3 + c});
      end
    end
  endtask

  task automatic applyStimulus(input int pix);
    bit ready;
    bit accepted;
    int tries;
    accepted = 1'b0;
    tries = 0;
    i_valid = 1'b1;
    i_image_pixel = DW'(pix);
    while (!accepted && tries < 64) begin
      ready = o_ready;
      @(negedge clk);
      tries++;
      if (ready) begin
        accepted = 1'b1;
        modelAccept(pix, edgeCnt);
      end
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic idleCycles(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendImage(input int rows, input int mode);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < D; c++) begin
        if (mode == 2) idleCycles($urandom_range(0, 2));
        applyStimulus(img[r][c]);
      end
      if (mode == 1) idleCycles(D);
    end
    i_valid = 1'b0;
  endtask

  task automatic resetDut(input int n);
    rst = 1'b1;
    i_valid = 1'b0;
    inReset = 1'b1;
    sbQ.delete();
    col = 0;
    rowsDone = 0;
    nextStart = 0;
    outIdx = 0;
    repeat (n) @(negedge clk);
    checkOutput("rst_valid", int'(o_valid), 0);
    checkOutput("rst_pixel", int'(o_conv_pixel), 0);
    checkOutput("rst_ready", int'(o_ready), 1);
    rst = 1'b0;
    lastOut = 0;
    inReset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * D + 20 && sbQ.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("sb_drain", sbQ.size(), 0);
  endtask

  task automatic fillImage(input int kind);
    for (int r = 0; r < MAXROWS; r++) begin
      for (int c = 0; c < D; c++) begin
        if (r >= 8) img[r][c] = 0;
        else if (kind == 0) img[r][c] = 100;
        else if (kind == 1) img[r][c] = (r == 2 && c == 3) ? 255 : 0;
        else img[r][c] = int'($urandom_range(0, 255));
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!inReset) begin
      if (o_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("pixel", int'(o_conv_pixel), e.pix);
          checkOutput("valid_edge", edgeCnt, e.expEdge);
        end
        if (outIdx < MAXROWS * D) outImg[outIdx / D][outIdx % D] = int'(o_conv_pixel);
        outIdx++;
        lastOut = int'(o_conv_pixel);
      end else begin
        checkOutput("hold", int'(o_conv_pixel), lastOut);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetDut(3);

    // Constant image: flat interior cancels, padded edges saturate.
    fillImage(0);
    sendImage(10, 1);
    drain();
    checkOutput("const_count", outIdx, 64);
    checkOutput("const_interior_a", outImg[1][3], 0);
    checkOutput("const_interior_b", outImg[4][5], 0);
    checkOutput("const_col0", outImg[0][0], 255);
    checkOutput("const_col7", outImg[3][7], 255);
    for (int c = 0; c < D; c++) checkOutput("const_flushrow", outImg[7][c], 0);

    // Single bright pixel.
    resetDut(2);
    fillImage(1);
    sendImage(10, 1);
    drain();
    checkOutput("imp_count", outIdx, 64);
    checkOutput("imp_centre", outImg[1][3], 255);
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 2; dc <= 4; dc++) begin
        if (!(dr == 1 && dc == 3)) checkOutput("imp_neighbour", outImg[dr][dc], 0);
      end
    end

    // Random image, gapless then with random gaps.
    resetDut(2);
    fillImage(2);
    sendImage(10, 0);
    drain();
    checkOutput("gapless_count", outIdx, 64);
    resetDut(2);
    sendImage(10, 2);
    drain();
    checkOutput("gapped_count", outIdx, 64);

    // Reset while a pass is producing output, then a fresh three-row image.
    resetDut(2);
    fillImage(2);
    sendImage(3, 0);
    idleCycles(5);
    resetDut(1);
    fillImage(2);
    sendImage(3, 1);
    drain();
    checkOutput("midreset_count", outIdx, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
